if_stage: RTL and testbench
===========================

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high.
REQ-002 Parameter RESET_PC, default 32'h0000_0000: PC value loaded by reset.
REQ-003 Parameter NOP_INSTR, default 32'h0000_0013: bubble instruction (addi x0,x0,0).
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 stall  input  1  hazard-unit hold; freezes PC and the IF/ID register.
REQ-007 bp_target  input  32  next-PC from the branch predictor, combinational from pc/instr.
REQ-008 bp_predict  input  1  predictor's taken-prediction for the instruction now in fetch.
REQ-009 bp_flush  input  1  EX-stage mispredict/JALR redirect; bp_target is then the corrected PC.
REQ-010 imem_addr  output  32  instruction-memory address, equal to pc.
REQ-011 imem_rdata  input  32  instruction word at imem_addr, combinational (same cycle).
REQ-012 pc  output  32  current fetch PC, fed to the predictor PC input.
REQ-013 instr  output  32  imem_rdata passthrough, fed to the predictor Instr input.
REQ-014 id_pc  output  32  IF/ID register: PC of the decoded instruction.
REQ-015 id_instr  output  32  IF/ID register: instruction word.
REQ-016 id_predict  output  1  IF/ID register: prediction bit, carried on to ID_EX.
REQ-017 id_valid  output  1  IF/ID register: 1 = real instruction, 0 = bubble.
REQ-018 flush_count  output  16  number of flush cycles accepted since reset.

Function
REQ-019 State: pc register; IF/ID register (id_pc, id_instr, id_predict, id_valid); flush_count counter; one-bit flush_d register.
REQ-020 Priority per edge: reset > bp_flush > stall > normal advance.
REQ-021 Normal advance (no reset, no flush, no stall): pc <= {bp_target[31:2],2'b00}. IF/ID <= {pc, imem_rdata, bp_predict, 1}.
REQ-022 Flush: pc <= {bp_target[31:2],2'b00}. IF/ID <= {pc, NOP_INSTR, 0, 0}. Flush overrides a simultaneous stall.
REQ-023 Stall without flush: pc and all IF/ID fields SHALL hold their values.
REQ-024 Cycle after a flush (flush_d=1): the IF/ID load SHALL force id_valid=0, id_instr=NOP_INSTR and id_predict=0. This discards the wrong-path word that the predictor's registered update may still present. pc advances normally.
REQ-025 A stall in that cycle SHALL hold the forced-bubble condition (flush_d held) until the first non-stalled edge consumes it.
REQ-026 Target bits [1:0] SHALL be discarded, so pc is always word-aligned.
REQ-027 Fetch latency: an instruction at pc appears on id_* at the next non-stalled, non-flushed edge (1 cycle).
REQ-028 pc arithmetic is 32-bit modulo. A target of 32'hFFFF_FFFC followed by PC+4 SHALL wrap to 32'h0000_0000 without any flag.
REQ-029 flush_count SHALL increment by 1 on every edge with bp_flush=1 and reset=0, including stalled edges. It wraps 16'hFFFF -> 16'h0000.
REQ-030 imem_addr, pc and instr SHALL be purely combinational from the pc register and imem_rdata; there is no extra register stage.
REQ-031 Back-to-back flushes on consecutive edges SHALL each redirect pc and each insert a bubble.

Reset
REQ-032 On a reset edge: pc=RESET_PC, id_pc=RESET_PC, id_instr=NOP_INSTR, id_predict=0, id_valid=0, flush_d=0, flush_count=0.
REQ-033 Reset SHALL take effect mid-stall and mid-flush, overriding both on the same edge.
REQ-034 First edge after reset release with no stall: id_pc=RESET_PC, id_instr=imem_rdata@RESET_PC, id_valid=1, pc=bp_target.

Verification
REQ-035 Sequential fetch: reset, then bp_target=pc+4 each cycle and imem returns 32'h00A00093 -> pc steps 0,4,8,12; id_pc lags pc by one cycle; id_valid=1 from the first edge.
REQ-036 Predicted-taken branch: pc=0x10, bp_target=0x40, bp_predict=1 -> next edge pc=0x40, id_pc=0x10, id_predict=1.
REQ-037 Mispredict: bp_flush=1 with stall=1 and bp_target=0x24 -> pc=0x24, id_valid=0, id_instr=0x00000013, flush_count+1; on the next edge id_valid=0 (forced bubble); on the edge after that id_valid=1.
REQ-038 Stall hold: stall=1 for 3 cycles at pc=0x08 -> pc, id_pc, id_instr and id_valid unchanged across all three edges; on release, pc=bp_target.
REQ-039 Wrap and alignment: bp_target=0xFFFF_FFFE -> pc=0xFFFF_FFFC; then bp_target=pc+4 -> pc=0x0000_0000. Also preload flush_count=0xFFFF plus one flush -> flush_count=0x0000.
REQ-040 Reset mid-operation: assert reset together with bp_flush=1 and stall=1 -> all REQ-032 values, and flush_count=0, not 1.

Source files
------------

// File: rtl/if_stage_if.sv
// Fetch-stage bus: branch-predictor inputs, hazard hold, instruction-memory
// port and the IF/ID register outputs, grouped as one bundle.
interface if_stage_if;
   logic        stall;
   logic [31:0] bp_target;
   logic        bp_predict;
   logic        bp_flush;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic [31:0] pc;
   logic [31:0] instr;
   logic [31:0] id_pc;
   logic [31:0] id_instr;
   logic        id_predict;
   logic        id_valid;
   logic [15:0] flush_count;

   // Fetch stage side
   modport slave (
      input  stall, bp_target, bp_predict, bp_flush, imem_rdata,
      output imem_addr, pc, instr, id_pc, id_instr, id_predict, id_valid,
             flush_count
   );

   // Surrounding pipeline / memory / predictor side
   modport master (
      output stall, bp_target, bp_predict, bp_flush, imem_rdata,
      input  imem_addr, pc, instr, id_pc, id_instr, id_predict, id_valid,
             flush_count
   );
endinterface

// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, IF/ID pipeline register, flush
// counter and a one-cycle "discard next word" flag set by each flush.
module if_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic       clk,
   input  logic       reset,
   if_stage_if.slave  bus
);

   logic [31:0] pc_q,          pc_d;
   logic [31:0] id_pc_q,       id_pc_d;
   logic [31:0] id_instr_q,    id_instr_d;
   logic        id_predict_q,  id_predict_d;
   logic        id_valid_q,    id_valid_d;
   logic        flush_pend_q,  flush_pend_d;
   logic [15:0] flush_count_q, flush_count_d;

   logic [31:0] target_aligned;
   assign target_aligned = {bus.bp_target[31:2], 2'b00};

   // Next-state selection: flush beats stall beats normal advance
   always_comb begin
      pc_d          = pc_q;
      id_pc_d       = id_pc_q;
      id_instr_d    = id_instr_q;
      id_predict_d  = id_predict_q;
      id_valid_d    = id_valid_q;
      flush_pend_d  = flush_pend_q;
      flush_count_d = flush_count_q;

      // Flushes are counted even when the pipeline is stalled
      if (bus.bp_flush) begin
         flush_count_d = flush_count_q + 16'd1;
      end

      if (bus.bp_flush) begin
         pc_d         = target_aligned;
         id_pc_d      = pc_q;
         id_instr_d   = NOP_INSTR;
         id_predict_d = 1'b0;
         id_valid_d   = 1'b0;
         flush_pend_d = 1'b1;
      end else if (!bus.stall) begin
         pc_d    = target_aligned;
         id_pc_d = pc_q;
         // The word fetched right after a redirect may still be wrong-path
         // because the predictor updates one cycle late; bubble it.
         if (flush_pend_q) begin
            id_instr_d   = NOP_INSTR;
            id_predict_d = 1'b0;
            id_valid_d   = 1'b0;
         end else begin
            id_instr_d   = bus.imem_rdata;
            id_predict_d = bus.bp_predict;
            id_valid_d   = 1'b1;
         end
         flush_pend_d = 1'b0;
      end
   end

   // State registers with synchronous reset overriding stall and flush
   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q          <= RESET_PC;
         id_pc_q       <= RESET_PC;
         id_instr_q    <= NOP_INSTR;
         id_predict_q  <= 1'b0;
         id_valid_q    <= 1'b0;
         flush_pend_q  <= 1'b0;
         flush_count_q <= 16'd0;
      end else begin
         pc_q          <= pc_d;
         id_pc_q       <= id_pc_d;
         id_instr_q    <= id_instr_d;
         id_predict_q  <= id_predict_d;
         id_valid_q    <= id_valid_d;
         flush_pend_q  <= flush_pend_d;
         flush_count_q <= flush_count_d;
      end
   end

   assign bus.pc          = pc_q;
   assign bus.imem_addr   = pc_q;
   assign bus.instr       = bus.imem_rdata;
   assign bus.id_pc       = id_pc_q;
   assign bus.id_instr    = id_instr_q;
   assign bus.id_predict  = id_predict_q;
   assign bus.id_valid    = id_valid_q;
   assign bus.flush_count = flush_count_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: expected post-edge state is queued with each
// stimulus step and compared 1 time unit after the following rising edge.
module tb_if_stage;

   localparam logic [31:0] NOP  = 32'h0000_0013;
   localparam logic [31:0] SEQW = 32'h00A0_0093;

   logic clk;
   logic reset;
   if_stage_if bus ();

   if_stage dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Memory and predictor models
   logic        mem_const;
   logic        tgt_seq;
   logic [31:0] tgt_val;

   function automatic logic [31:0] mem_word(input logic [31:0] a, input logic c);
      return c ? SEQW : (32'hC0DE_0000 ^ a);
   endfunction

   assign bus.imem_rdata = mem_word(bus.imem_addr, mem_const);
   assign bus.bp_target  = tgt_seq ? (bus.pc + 32'd4) : tgt_val;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] id_pc;
      logic [31:0] id_instr;
      logic        id_predict;
      logic        id_valid;
      logic [15:0] fc;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   fails  = 0;
   int   step_no = 0;

   task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL step %0d %s observed=%h expected=%h", step_no, tag, obs, exp);
      end
   endtask

   task automatic push(input logic [31:0] p, input logic [31:0] ip, input logic [31:0] ii,
                       input logic pr, input logic v, input logic [15:0] fc);
      exp_t e;
      e.pc = p; e.id_pc = ip; e.id_instr = ii; e.id_predict = pr; e.id_valid = v; e.fc = fc;
      sb.push_back(e);
   endtask

   // Advance one edge, then pop the oldest expectation and compare
   task automatic tick();
      exp_t e;
      @(posedge clk);
      #1;
      step_no++;
      checks++;
      assert (sb.size() > 0) else begin
         fails++;
         $error("FAIL step %0d scoreboard observed=empty expected=entry", step_no);
      end
      if (sb.size() > 0) begin
         e = sb.pop_front();
         check32("pc",          bus.pc,                 e.pc);
         check32("imem_addr",   bus.imem_addr,          e.pc);
         check32("instr",       bus.instr,              mem_word(e.pc, mem_const));
         check32("id_pc",       bus.id_pc,              e.id_pc);
         check32("id_instr",    bus.id_instr,           e.id_instr);
         check32("id_predict",  {31'd0, bus.id_predict}, {31'd0, e.id_predict});
         check32("id_valid",    {31'd0, bus.id_valid},   {31'd0, e.id_valid});
         check32("flush_count", {16'd0, bus.flush_count}, {16'd0, e.fc});
         $display("step %0d pc=%h id_pc=%h id_instr=%h pred=%b valid=%b fc=%h",
                  step_no, bus.pc, bus.id_pc, bus.id_instr, bus.id_predict,
                  bus.id_valid, bus.flush_count);
      end
   endtask

   initial begin
      reset = 1'b1;
      bus.stall = 1'b0; bus.bp_flush = 1'b0; bus.bp_predict = 1'b0;
      mem_const = 1'b1; tgt_seq = 1'b1; tgt_val = 32'd0;

      // Reset state
      push(32'h0, 32'h0, NOP, 1'b0, 1'b0, 16'd0); tick();
      reset = 1'b0;

      // Sequential fetch
      push(32'h4, 32'h0, SEQW, 1'b0, 1'b1, 16'd0); tick();
      push(32'h8, 32'h4, SEQW, 1'b0, 1'b1, 16'd0); tick();

      // Stall hold at pc=0x08 for three edges, then release
      bus.stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         push(32'h8, 32'h4, SEQW, 1'b0, 1'b1, 16'd0); tick();
      end
      bus.stall = 1'b0;
      push(32'hC, 32'h8, SEQW, 1'b0, 1'b1, 16'd0); tick();
      push(32'h10, 32'hC, SEQW, 1'b0, 1'b1, 16'd0); tick();

      // Predicted-taken branch at 0x10 to 0x40
      mem_const = 1'b0; tgt_seq = 1'b0; tgt_val = 32'h40; bus.bp_predict = 1'b1;
      push(32'h40, 32'h10, 32'hC0DE_0010, 1'b1, 1'b1, 16'd0); tick();

      // Mispredict with simultaneous stall: flush wins
      bus.bp_flush = 1'b1; bus.stall = 1'b1; tgt_val = 32'h24;
      push(32'h24, 32'h40, NOP, 1'b0, 1'b0, 16'd1); tick();
      bus.bp_flush = 1'b0; bus.stall = 1'b0; tgt_seq = 1'b1;
      push(32'h28, 32'h24, NOP, 1'b0, 1'b0, 16'd1); tick();
      bus.bp_predict = 1'b0;
      push(32'h2C, 32'h28, 32'hC0DE_0028, 1'b0, 1'b1, 16'd1); tick();

      // Stall during the forced-bubble cycle keeps the bubble pending
      bus.bp_flush = 1'b1;
      push(32'h30, 32'h2C, NOP, 1'b0, 1'b0, 16'd2); tick();
      bus.bp_flush = 1'b0; bus.stall = 1'b1; bus.bp_predict = 1'b1;
      push(32'h30, 32'h2C, NOP, 1'b0, 1'b0, 16'd2); tick();
      bus.stall = 1'b0;
      push(32'h34, 32'h30, NOP, 1'b0, 1'b0, 16'd2); tick();
      push(32'h38, 32'h34, 32'hC0DE_0034, 1'b1, 1'b1, 16'd2); tick();
      bus.bp_predict = 1'b0;

      // Back-to-back flushes
      bus.bp_flush = 1'b1; tgt_seq = 1'b0; tgt_val = 32'h100;
      push(32'h100, 32'h38, NOP, 1'b0, 1'b0, 16'd3); tick();
      tgt_val = 32'h203;
      push(32'h200, 32'h100, NOP, 1'b0, 1'b0, 16'd4); tick();
      bus.bp_flush = 1'b0; tgt_seq = 1'b1;
      push(32'h204, 32'h200, NOP, 1'b0, 1'b0, 16'd4); tick();
      push(32'h208, 32'h204, 32'hC0DE_0204, 1'b0, 1'b1, 16'd4); tick();

      // Alignment and 32-bit wrap
      tgt_seq = 1'b0; tgt_val = 32'hFFFF_FFFE;
      push(32'hFFFF_FFFC, 32'h208, 32'hC0DE_0208, 1'b0, 1'b1, 16'd4); tick();
      tgt_seq = 1'b1;
      push(32'h0, 32'hFFFF_FFFC, 32'h3F21_FFFC, 1'b0, 1'b1, 16'd4); tick();

      // Reset together with flush and stall
      reset = 1'b1; bus.bp_flush = 1'b1; bus.stall = 1'b1;
      push(32'h0, 32'h0, NOP, 1'b0, 1'b0, 16'd0); tick();
      reset = 1'b0; bus.bp_flush = 1'b0; bus.stall = 1'b0;
      push(32'h4, 32'h0, 32'hC0DE_0000, 1'b0, 1'b1, 16'd0); tick();

      // flush_count wrap: 65535 flushes (half of them stalled), then one more
      bus.bp_flush = 1'b1;
      for (int i = 0; i < 65535; i++) begin
         bus.stall = i[0];
         @(posedge clk);
         #1;
      end
      bus.stall = 1'b0;
      check32("flush_count_max", {16'd0, bus.flush_count}, 32'h0000_FFFF);
      $display("flush_count after 65535 flushes=%h", bus.flush_count);
      @(posedge clk);
      #1;
      check32("flush_count_wrap", {16'd0, bus.flush_count}, 32'h0000_0000);
      $display("flush_count after one more flush=%h", bus.flush_count);
      bus.bp_flush = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
